// File: rtl/halfband_pkg.sv
// Shared constants, coefficient table and FSM state type for the x2 half-band
// interpolator and its decimator counterpart.
package halfband_pkg;

  localparam int PCM_W   = 24;
  localparam int PCM_MAX = 8388607;
  localparam int PCM_MIN = -8388608;

  localparam int HB_K      = 6;
  localparam int HB_COEF_W = 18;

  // Q1.17 pair weights, outermost pair first; they sum to 2^16 so the FIR
  // phase has unity DC gain once each weight is applied to a pair of taps.
  localparam logic signed [HB_COEF_W-1:0] HB_COEF [HB_K] = '{
    18'sd256, -18'sd1024, 18'sd2816, -18'sd6656, 18'sd20096, 18'sd50048
  };

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_MAC     = 3'd1,
    ST_RND     = 3'd2,
    ST_OUT_FIR = 3'd3,
    ST_OUT_CTR = 3'd4
  } hb_state_e;

endpackage

// File: rtl/pcm_sat_round.sv
// Combinational accumulator-to-PCM stage: round half up, arithmetic shift,
// then clamp to the signed 24-bit range.
module pcm_sat_round
  import halfband_pkg::*;
#(
  parameter int ACC_W = 48,
  parameter int SHIFT = 17
) (
  input  logic signed [ACC_W-1:0] acc,
  output logic signed [PCM_W-1:0] pcm
);

  localparam logic signed [ACC_W-1:0] HALF = ACC_W'(64'd1 << (SHIFT - 1));
  localparam logic signed [ACC_W-1:0] MAXV = ACC_W'(PCM_MAX);
  localparam logic signed [ACC_W-1:0] MINV = ACC_W'(PCM_MIN);

  logic signed [ACC_W-1:0] biased;
  logic signed [ACC_W-1:0] shifted;

  always_comb begin
    biased  = acc + HALF;
    shifted = biased >>> SHIFT;
    if (shifted > MAXV) begin
      pcm = MAXV[PCM_W-1:0];
    end else if (shifted < MINV) begin
      pcm = MINV[PCM_W-1:0];
    end else begin
      pcm = shifted[PCM_W-1:0];
    end
  end

endmodule

// File: rtl/halfband_interp_pcm_2.sv
// x2 half-band interpolator: per accepted sample, emits the FIR phase (one
// symmetric pair per cycle through a single multiplier) then the centre tap.
module halfband_interp_pcm_2
  import halfband_pkg::*;
#(
  parameter int K      = HB_K,
  parameter int COEF_W = HB_COEF_W,
  parameter int ACC_W  = 48
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic signed [PCM_W-1:0] in,
  output logic                    in_ready,
  output logic signed [PCM_W-1:0] out,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    overrun,
  output hb_state_e               state
);

  // Handshakes: an input is taken on a rising edge where enable && in_ready;
  // an output moves on a rising edge where out_valid && out_ready, and out
  // is frozen for as long as out_valid is high and out_ready is low.

  localparam int TAPS   = 2 * K;
  localparam int KW     = $clog2(K);
  localparam int TW     = $clog2(TAPS);
  localparam int PRE_W  = PCM_W + 1;
  localparam int PROD_W = PRE_W + COEF_W;

  logic signed [PCM_W-1:0]  d [TAPS];
  logic        [KW-1:0]     k;
  logic signed [ACC_W-1:0]  acc;
  logic        [TW-1:0]     near_idx;
  logic        [TW-1:0]     far_idx;
  logic signed [COEF_W-1:0] coef;
  logic signed [PRE_W-1:0]  pre;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [PCM_W-1:0]  rnd_pcm;

  // Datapath for the pair selected by k: pre-add, multiply, sign-extend.
  always_comb begin
    near_idx = TW'(k);
    far_idx  = TW'(TAPS - 1) - near_idx;
    coef     = COEF_W'(HB_COEF[k]);
    pre      = PRE_W'(d[near_idx]) + PRE_W'(d[far_idx]);
    prod     = PROD_W'(coef) * PROD_W'(pre);
    prod_ext = ACC_W'(prod);
  end

  pcm_sat_round #(
    .ACC_W (ACC_W),
    .SHIFT (COEF_W - 1)
  ) u_sat_round (
    .acc (acc),
    .pcm (rnd_pcm)
  );

  assign in_ready = (state == ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      k         <= '0;
      acc       <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
      for (int i = 0; i < TAPS; i++) d[i] <= '0;
    end else begin
      if (enable && (state != ST_IDLE)) overrun <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (enable) begin
            d[0] <= in;
            for (int i = 1; i < TAPS; i++) d[i] <= d[i-1];
            acc   <= '0;
            k     <= '0;
            state <= ST_MAC;
          end
        end
        ST_MAC: begin
          acc <= acc + prod_ext;
          k   <= k + KW'(1);
          if (k == KW'(K - 1)) state <= ST_RND;
        end
        ST_RND: begin
          out       <= rnd_pcm;
          out_valid <= 1'b1;
          state     <= ST_OUT_FIR;
        end
        ST_OUT_FIR: begin
          if (out_ready) begin
            out   <= d[K-1];
            state <= ST_OUT_CTR;
          end
        end
        ST_OUT_CTR: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/halfband_interp_pcm_2.md
# halfband_interp_pcm_2

Half-band ×2 interpolator for the 24-bit PCM path feeding the delta-sigma modulator. It is the transmit-side counterpart of the ×2 half-band decimator. Each accepted input sample produces two output samples: the FIR (even) phase first, then the centre-tap (odd) phase. It uses a polyphase, symmetric-pair structure with a single time-multiplexed multiplier and round-plus-saturate to 24 bits.

## Interface
- `K`, 6: number of symmetric coefficient pairs in the FIR phase. The delay line is 2K samples (23-tap half-band).
- `COEF_W`, 18: coefficient width, signed Q1.(COEF_W-1).
- `ACC_W`, 48: accumulator width.
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `enable` in 1: input-valid strobe; `in` is sampled when `enable && in_ready`.
- `in` in 24: signed PCM input sample.
- `in_ready` out 1: high only in IDLE.
- `out` out 24: signed PCM output sample, held stable while `out_valid` is high.
- `out_valid` out 1: output sample valid.
- `out_ready` in 1: downstream accept; transfer occurs when `out_valid && out_ready`.
- `overrun` out 1: sticky flag, set when `enable` is high while `in_ready` is low. Cleared only by reset.

## Operation
- **Delay line** `d[0..2K-1]`, where `d[0]` is newest. On input accept it shifts by one and `d[0]` takes `in`.
- **FIR output (first of each pair):** y_fir = sat24(round((Σ_{k=0..K-1} HB_COEF[k]·(d[k]+d[2K-1-k])) >>> (COEF_W-1))).
  - Pre-add is 25-bit, product is 43-bit, accumulation is ACC_W bits; no wrap is possible.
- **Rounding:** add 2^(COEF_W-2) before the arithmetic shift.
- **Saturation:** results above 8388607 become 8388607; results below -8388608 become -8388608.
- **Centre output (second of each pair):** `d[K-1]` passed through unchanged. The passband gain of 2 is absorbed into the coefficients.
- **FSM states:**
  - IDLE: `in_ready`=1. On accept, shift the line, clear the accumulator and k, go to MAC.
  - MAC: one pair per cycle, k = 0..K-1. After k = K-1, go to RND.
  - RND: round/saturate into the output register, set `out_valid`, go to OUT_FIR.
  - OUT_FIR: hold `out`. On transfer, load `d[K-1]` into `out`, keep `out_valid` high, go to OUT_CTR.
  - OUT_CTR: hold `out`. On transfer, drop `out_valid`, go to IDLE.
- **Dropped inputs:** `enable` outside IDLE is ignored. The delay line is unchanged and `overrun` is set.
- **Reset** (any time, including mid-MAC or with `out_valid` high):
  - delay line, accumulator, k and `out` go to 0;
  - `out_valid` and `overrun` go to 0;
  - state goes to IDLE, so `in_ready`=1.
  - No partial output is emitted after reset.

## Timing
- Input accepted at cycle t.
- MAC occupies cycles t+1 .. t+K.
- RND at t+K+1.
- `out_valid` rises at t+K+2 with the FIR sample.
- With `out_ready` held high:
  - the FIR sample transfers at t+K+2;
  - the centre sample transfers at t+K+3;
  - `in_ready` is high again at t+K+4.
- Minimum input spacing is K+4 cycles (10 for K=6).
- `out_valid` never drops without a transfer, and `out` never changes while `out_valid` is high and `out_ready` is low.
- `in_ready` is decoded from state with no extra register stage. An accept and the final output transfer cannot coincide, because `in_ready` is 0 in OUT_CTR.

## Structure
- Package `halfband_pkg` holds:
  - `PCM_W` = 24, `PCM_MAX` = 8388607, `PCM_MIN` = -8388608;
  - coefficient array `HB_COEF[0..K-1]`, constrained so that ΣHB_COEF = 2^(COEF_W-2), which gives unity DC gain on the FIR phase;
  - the state enum.
- Sub-module `pcm_sat_round` (accumulator → rounded, saturated 24-bit) is combinational and shared with the decimator output path.

## Test plan
- **Reset:** assert `rst_n`=0 mid-MAC → `out`=0, `out_valid`=0, `overrun`=0, `in_ready`=1. After release, the first `out_valid` appears only after a new accept.
- **Impulse:** `in`=8388607 once, then zeros, `out_ready`=1.
  - FIR outputs of pairs 0..K-1 equal round(HB_COEF[k]·8388607/2^17), in the order given by the tap position.
  - Centre output of pair K-1 is 8388607; all other centre outputs are 0.
- **DC:** `in`=1000000 for 20 samples → from pair 2K-1 on, both outputs are within ±1 LSB of 1000000.
- **Saturation:** 12 samples of -8388608, then a step to 8388607 → the FIR overshoot clamps `out` to exactly 8388607 and never wraps negative.
- **Backpressure:** hold `out_ready`=0 for 10 cycles after `out_valid` rises.
  - `out` stays stable and `in_ready`=0.
  - Pulse `enable` with `in`=5 → `overrun`=1, and subsequent outputs are unaffected by the value 5.
- **Throughput:** `enable` every 10 cycles with `out_ready`=1 → no overrun, and exactly 2 `out_valid` transfers per input.
